dcache_victim_wb: RTL and testbench

- Write-back transmitter for the data cache: takes one evicted 256-bit line, read out as the data bank's full-line output, and emits it to memory as a single AXI4 write burst (INCR, 8 beats x 32 bit).
- Counterpart of the refill path that writes whole lines into the data bank.
- Sits between the cache controller (victim handoff) and the AXI write channels of the bus interface.

---
 rtl/cache_axi_pkg.sv | 17 +
 rtl/line_word_sel.sv | 21 ++
 rtl/dcache_victim_wb.sv | 164 ++++++++++++++++
 tb/tb_dcache_victim_wb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_pkg.sv
// Shared types and AXI encodings for the data-cache bus paths.
// Used by the victim write-back transmitter and its line word selector.
package cache_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wb_state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam int         LINE_BYTES_LOG2 = 5;

endpackage

// File: rtl/line_word_sel.sv
// Picks one 32-bit word out of a full cache line; word i is bits [32i+31:32i].
// Feeds both the write-data beat and the forwarding read port.
module line_word_sel #(
  parameter int WORDS = 8
) (
  input  logic [32*WORDS-1:0]       i_line,
  input  logic [$clog2(WORDS)-1:0]  i_idx,
  output logic [31:0]               o_word
);

  logic [31:0] w_words [WORDS];

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_split
      assign w_words[gi] = i_line[32*gi +: 32];
    end
  endgenerate

  assign o_word = w_words[i_idx];

endmodule

// File: rtl/dcache_victim_wb.sv
// Victim write-back: buffers one evicted line and sends it as one AXI4 INCR write burst.
// Optional DCACHE_WB_FORWARD_EN adds a read port that serves loads from the line in flight.
module dcache_victim_wb
  import cache_axi_pkg::*;
#(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] AXI_ID     = 4'd1,
  parameter int         ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [32*LINE_WORDS-1:0] req_line,
  output logic [3:0]               awid,
  output logic [ADDR_WIDTH-1:0]    awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic                     wb_done,
  output logic                     wb_err
`ifdef DCACHE_WB_FORWARD_EN
  ,
  input  logic [ADDR_WIDTH-1:0]    fwd_addr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data
`endif
);

  localparam int              CNT_W    = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

  wb_state_t                 r_state;
  logic [ADDR_WIDTH-1:0]     r_base;
  logic [32*LINE_WORDS-1:0]  r_line;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_req_ready;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic                      r_wlast;
  logic                      r_bready;
  logic                      r_wb_done;
  logic                      r_wb_err;

  logic [CNT_W-1:0]          w_cnt_inc;
  logic [31:0]               w_wdata;
  logic                      w_unused;

  assign w_cnt_inc = r_cnt + 1'b1;

  // Byte offset within the line is never sent; bresp[0] only splits EXOKAY/DECERR.
  assign w_unused = ^{req_addr[LINE_BYTES_LOG2-1:0], bresp[0]};

  line_word_sel #(
    .WORDS (LINE_WORDS)
  ) u_wdata_sel (
    .i_line (r_line),
    .i_idx  (r_cnt),
    .o_word (w_wdata)
  );

  assign req_ready = r_req_ready;
  assign awid      = AXI_ID;
  assign awaddr    = r_base;
  assign awlen     = 8'(LINE_WORDS - 1);
  assign awsize    = AXI_SIZE_4B;
  assign awburst   = AXI_BURST_INCR;
  assign awvalid   = r_awvalid;
  assign wdata     = w_wdata;
  assign wstrb     = 4'hF;
  assign wlast     = r_wlast;
  assign wvalid    = r_wvalid;
  assign bready    = r_bready;
  assign wb_done   = r_wb_done;
  assign wb_err    = r_wb_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_bready    <= 1'b0;
      r_wb_done   <= 1'b0;
      r_wb_err    <= 1'b0;
    end else begin
      r_wb_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_base      <= {req_addr[ADDR_WIDTH-1:LINE_BYTES_LOG2], {LINE_BYTES_LOG2{1'b0}}};
            r_line      <= req_line;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_awvalid   <= 1'b1;
            r_state     <= ADDR;
          end
        end
        ADDR: begin
          if (awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= (LAST_IDX == '0);
            r_state   <= DATA;
          end
        end
        DATA: begin
          // A stalled beat leaves counter and wlast untouched, so wdata holds too.
          if (wready) begin
            r_cnt   <= w_cnt_inc;
            r_wlast <= (w_cnt_inc == LAST_IDX);
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= RESP;
            end
          end
        end
        RESP: begin
          if (bvalid) begin
            r_bready    <= 1'b0;
            r_wb_done   <= 1'b1;
            r_wb_err    <= r_wb_err | bresp[1];
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_WB_FORWARD_EN
  logic w_fwd_unused;

  assign w_fwd_unused = ^fwd_addr[1:0];

  assign fwd_hit = (r_state != IDLE) &&
                   (fwd_addr[ADDR_WIDTH-1:LINE_BYTES_LOG2] == r_base[ADDR_WIDTH-1:LINE_BYTES_LOG2]);

  line_word_sel #(
    .WORDS (LINE_WORDS)
  ) u_fwd_sel (
    .i_line (r_line),
    .i_idx  (fwd_addr[2 +: CNT_W]),
    .o_word (fwd_data)
  );
`endif

endmodule

// File: tb/tb_dcache_victim_wb.sv
// Self-checking bench for dcache_victim_wb: vector table, hand sequences, randomized bursts.
// Define DCACHE_WB_FORWARD_EN to also exercise the forwarding port.
module tb_dcache_victim_wb;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [255:0] req_line;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic         wb_done;
  logic         wb_err;
`ifdef DCACHE_WB_FORWARD_EN
  logic [31:0]  fwd_addr;
  logic         fwd_hit;
  logic [31:0]  fwd_data;
`endif

  dcache_victim_wb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_line  (req_line),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .wb_done   (wb_done),
    .wb_err    (wb_err)
`ifdef DCACHE_WB_FORWARD_EN
    ,
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic m_err = 1'b0;   // reference model: sticky error flag

  typedef struct {
    logic [31:0] addr;
    logic [31:0] w0;
    int          aw_dly;
    int          w_mode;     // 0 always ready, 1 toggle 1010.., 2 random
    logic [1:0]  rsp;
    int          b_dly;
    bit          chk_lat;
    logic [31:0] exp_awaddr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] w0);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = w0 + 32'(i);
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  task automatic run_burst(input logic [31:0] addr, input logic [255:0] line,
                           input int aw_dly, input int w_mode, input logic [1:0] rsp,
                           input int b_dly, input bit stray, input bit chk_lat,
                           input bit keep_valid, input logic [31:0] next_addr,
                           input logic [255:0] next_line);
    logic [31:0] exp_awaddr;
    int          c;
    int          beats;
    int          bwait;
    bit          aw_done;
    bit          done;
    bit          b_hs;
    bit          tog;
    bit          prev_stall;
    logic [31:0] prev_wdata;
    logic        prev_wlast;
`ifdef DCACHE_WB_FORWARD_EN
    bit          fwd_done;
`endif
    exp_awaddr = addr & 32'hFFFF_FFE0;
    c = 0;
    while (!req_ready && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("req_ready_idle", 64'(req_ready), 64'd1);
`ifdef DCACHE_WB_FORWARD_EN
    fwd_addr = addr;
    #1;
    check("fwd_hit_idle", 64'(fwd_hit), 64'd0);
    fwd_done = 0;
`endif
    req_valid = 1'b1;
    req_addr  = addr;
    req_line  = line;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    @(posedge clk); #1;
    if (keep_valid) begin
      req_addr = next_addr;
      req_line = next_line;
    end else begin
      req_valid = 1'b0;
      req_line  = rand_line();
    end
    check("awid", 64'(awid), 64'd1);
    check("awlen", 64'(awlen), 64'd7);
    check("awsize", 64'(awsize), 64'd2);
    check("awburst", 64'(awburst), 64'd1);
    check("wstrb", 64'(wstrb), 64'hF);
    c = 0; beats = 0; bwait = 0; aw_done = 0; done = 0; tog = 1; prev_stall = 0;
    prev_wdata = '0; prev_wlast = 1'b0;
    while (!done && c < 300) begin
      check("req_ready_busy", 64'(req_ready), 64'd0);
      check("wb_done_quiet", 64'(wb_done), 64'd0);
      if (awvalid) check("awaddr", 64'(awaddr), 64'(exp_awaddr));
      if (wvalid) check("w_after_aw", 64'(aw_done), 64'd1);
      if (prev_stall) begin
        check("stall_wvalid", 64'(wvalid), 64'd1);
        check("stall_wdata", 64'(wdata), 64'(prev_wdata));
        check("stall_wlast", 64'(wlast), 64'(prev_wlast));
      end
`ifdef DCACHE_WB_FORWARD_EN
      if (wvalid && !fwd_done) begin
        fwd_done = 1;
        fwd_addr = exp_awaddr + 32'h14;
        #1;
        check("fwd_hit_in", 64'(fwd_hit), 64'd1);
        check("fwd_data", 64'(fwd_data), 64'(line[191:160]));
        fwd_addr = exp_awaddr + 32'h20;
        #1;
        check("fwd_hit_next_line", 64'(fwd_hit), 64'd0);
      end
`endif
      awready = (c >= aw_dly);
      case (w_mode)
        0:       wready = 1'b1;
        1:       wready = tog;
        default: wready = 1'($urandom_range(0, 1));
      endcase
      if (wvalid) tog = !tog;
      if (bready) begin
        bvalid = (bwait >= b_dly);
        bresp  = rsp;
        bwait++;
      end else begin
        bvalid = stray && ($urandom_range(0, 2) == 0);
        bresp  = 2'b10;
      end
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) begin
        if (beats < 8) check("wdata", 64'(wdata), 64'(line[32*beats +: 32]));
        check("wlast", 64'(wlast), 64'(beats == 7));
        beats++;
      end
      prev_stall = wvalid && !wready;
      prev_wdata = wdata;
      prev_wlast = wlast;
      b_hs = bready && bvalid;
      @(posedge clk); #1;
      c++;
      if (b_hs) done = 1;
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    check("burst_completed", 64'(done), 64'd1);
    if (done) begin
      m_err = m_err | rsp[1];
      check("wb_done_pulse", 64'(wb_done), 64'd1);
      check("req_ready_back", 64'(req_ready), 64'd1);
      check("wb_err", 64'(wb_err), 64'(m_err));
      check("beat_count", 64'(beats), 64'd8);
      check("bready_drop", 64'(bready), 64'd0);
      if (chk_lat) check("latency", 64'(c), 64'd10);
      if (!keep_valid) begin
        @(posedge clk); #1;
        check("wb_done_one_cycle", 64'(wb_done), 64'd0);
      end
    end
    $display("burst addr=%08h awaddr=%08h beats=%0d cycles=%0d bresp=%0d wb_err=%0b",
             addr, exp_awaddr, beats, c, rsp, wb_err);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] line;
    logic [255:0] line2;
    logic [31:0]  raddr;

    vecs[0] = '{32'h1000_0024, 32'h0000_00A0, 0, 0, 2'b00, 0, 1'b1, 32'h1000_0020, 1'b0};
    vecs[1] = '{32'h2000_005F, 32'h0000_00B0, 3, 1, 2'b00, 1, 1'b0, 32'h2000_0040, 1'b0};
    vecs[2] = '{32'h3000_0001, 32'h0000_00C0, 0, 0, 2'b10, 0, 1'b0, 32'h3000_0000, 1'b1};
    vecs[3] = '{32'h4000_0100, 32'h0000_00D0, 1, 1, 2'b00, 2, 1'b0, 32'h4000_0100, 1'b1};
    vecs[4] = '{32'h5000_00FF, 32'h0000_00E0, 0, 0, 2'b11, 0, 1'b0, 32'h5000_00E0, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_line = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
`ifdef DCACHE_WB_FORWARD_EN
    fwd_addr = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_wlast", 64'(wlast), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_wb_done", 64'(wb_done), 64'd0);
    check("rst_wb_err", 64'(wb_err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table: basic, backpressure, SLVERR, sticky error, DECERR
    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i].addr, make_line(vecs[i].w0), vecs[i].aw_dly, vecs[i].w_mode,
                vecs[i].rsp, vecs[i].b_dly, 1'b0, vecs[i].chk_lat, 1'b0, '0, '0);
      check("tbl_wb_err", 64'(wb_err), 64'(vecs[i].exp_err));
    end

    // Handoff: req_valid held high through a burst with the next line waiting
    line  = make_line(32'h1111_0000);
    line2 = make_line(32'h2222_0000);
    run_burst(32'h0000_6000, line, 0, 0, 2'b00, 1, 1'b0, 1'b0, 1'b1, 32'h0000_7020, line2);
    run_burst(32'h0000_7020, line2, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Reset in the middle of DATA after three beats
    line = make_line(32'h7700_0000);
    req_addr = 32'h0000_8000; req_line = line; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_wvalid", 64'(wvalid), 64'd1);
    check("pre_rst_wdata", 64'(wdata), 64'(line[127:96]));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_err = 1'b0;
    check("mid_rst_wvalid", 64'(wvalid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_awvalid", 64'(awvalid), 64'd0);
    check("mid_rst_wb_err", 64'(wb_err), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_beat_after_rst", 64'(wvalid), 64'd0);
    end
    awready = 1'b0; wready = 1'b0;
    run_burst(32'h0000_9000, make_line(32'h8800_0000), 0, 0, 2'b00, 0, 1'b0, 1'b1, 1'b0, '0, '0);

    // Randomized bursts with random backpressure, responses and stray bvalid
    for (int i = 0; i < 20; i++) begin
      raddr = $urandom();
      run_burst(raddr, rand_line(), int'($urandom_range(0, 3)), 2,
                2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, 1'b0,
                1'b0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
